// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the MIPS pipeline controller: PC source and forwarding
// select codes, FSM state type, and the forwarding-priority helper.
package pipeline_ctrl_pkg;

    localparam logic [2:0] PC_NEXT     = 3'd0;
    localparam logic [2:0] PC_JUMP     = 3'd1;
    localparam logic [2:0] PC_FWD_DATA = 3'd2;
    localparam logic [2:0] PC_BRANCH   = 3'd3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_DIN = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    // EXE result wins over MEM; a load still in EXE has no data yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] exe_addr,
        input logic       exe_wen,
        input logic       exe_load,
        input logic [4:0] mem_addr,
        input logic       mem_wen,
        input logic       mem_ren
    );
        if (src == 5'd0)
            return FWD_RF;
        else if (exe_wen && !exe_load && exe_addr == src)
            return FWD_EXE;
        else if (mem_wen && mem_ren && mem_addr == src)
            return FWD_DIN;
        else if (mem_wen && mem_addr == src)
            return FWD_MEM;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection: ID-stage forwarding selects, load-use
// stall request and store-data forward from WB.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_addr_rs_id,
    input  logic [4:0] i_addr_rt_id,
    input  logic       i_rs_used,
    input  logic       i_rt_used,
    input  logic       i_is_store_id,
    input  logic [4:0] i_regw_addr_exe,
    input  logic [4:0] i_regw_addr_mem,
    input  logic       i_wb_wen_exe,
    input  logic       i_wb_wen_mem,
    input  logic       i_is_load_exe,
    input  logic       i_mem_ren_mem,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_load_use,
    output logic       o_fwd_m
);

    logic w_rs_hit_exe;
    logic w_rt_hit_exe;

    assign w_rs_hit_exe = (i_addr_rs_id != 5'd0) && (i_addr_rs_id == i_regw_addr_exe);
    assign w_rt_hit_exe = (i_addr_rt_id != 5'd0) && (i_addr_rt_id == i_regw_addr_exe);

    assign o_fwd_a = fwd_sel(i_addr_rs_id, i_regw_addr_exe, i_wb_wen_exe, i_is_load_exe,
                             i_regw_addr_mem, i_wb_wen_mem, i_mem_ren_mem);
    assign o_fwd_b = fwd_sel(i_addr_rt_id, i_regw_addr_exe, i_wb_wen_exe, i_is_load_exe,
                             i_regw_addr_mem, i_wb_wen_mem, i_mem_ren_mem);

    // A store's rt is consumed late, so it is served from WB instead of stalling.
    assign o_load_use = i_is_load_exe && i_wb_wen_exe &&
                        ((i_rs_used && w_rs_hit_exe) ||
                         (i_rt_used && !i_is_store_id && w_rt_hit_exe));
    assign o_fwd_m    = i_is_store_id && i_is_load_exe && w_rt_hit_exe;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stage-sequencing controller for the 5-stage MIPS pipeline with
// variable-latency memory wait FSM, timeout flag and performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 32,
    parameter bit DELAY_SLOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       addr_rs_id,
    input  logic [4:0]       addr_rt_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             is_store_id,
    input  logic             is_beq,
    input  logic             is_bne,
    input  logic [2:0]       pc_src_dec,
    input  logic             a_b_equal,
    input  logic [4:0]       regw_addr_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_exe,
    input  logic             wb_wen_mem,
    input  logic             is_load_exe,
    input  logic             mem_ren_mem,
    input  logic             mem_wen_mem,
    input  logic             inst_ack,
    input  logic             mem_ack,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [1:0]       fwd_a_ctrl,
    output logic [1:0]       fwd_b_ctrl,
    output logic             fwd_m,
    output logic [2:0]       pc_src_ctrl,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_load_use, w_fwd_m;
    logic       w_mem_stall, w_taken, w_redirect, w_stall, w_flush;
    logic [2:0] w_pc_res;

    hazard_detect u_hazard_detect (
        .i_addr_rs_id   (addr_rs_id),
        .i_addr_rt_id   (addr_rt_id),
        .i_rs_used      (rs_used),
        .i_rt_used      (rt_used),
        .i_is_store_id  (is_store_id),
        .i_regw_addr_exe(regw_addr_exe),
        .i_regw_addr_mem(regw_addr_mem),
        .i_wb_wen_exe   (wb_wen_exe),
        .i_wb_wen_mem   (wb_wen_mem),
        .i_is_load_exe  (is_load_exe),
        .i_mem_ren_mem  (mem_ren_mem),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b),
        .o_load_use     (w_load_use),
        .o_fwd_m        (w_fwd_m)
    );

    assign w_mem_stall = (mem_ren_mem || mem_wen_mem) && !mem_ack;
    assign w_taken     = (is_beq && a_b_equal) || (is_bne && !a_b_equal);
    assign w_redirect  = w_taken || pc_src_dec == PC_JUMP || pc_src_dec == PC_FWD_DATA;
    assign w_pc_res    = w_taken ? PC_BRANCH : ((is_beq || is_bne) ? PC_NEXT : pc_src_dec);

    always_comb begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '0;
        {if_en, id_en, exe_en, mem_en, wb_en}      = '1;
        fwd_a_ctrl  = w_fwd_a;
        fwd_b_ctrl  = w_fwd_b;
        fwd_m       = w_fwd_m;
        pc_src_ctrl = w_pc_res;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (rst) begin
            {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '1;
            fwd_a_ctrl  = FWD_RF;
            fwd_b_ctrl  = FWD_RF;
            fwd_m       = 1'b0;
            pc_src_ctrl = PC_NEXT;
        end else if (w_mem_stall) begin
            {if_en, id_en, exe_en, mem_en, wb_en} = '0;
            w_stall = 1'b1;
        end else if (w_load_use) begin
            // Branch compare may use stale data here; retry after the bubble.
            if_en       = 1'b0;
            id_en       = 1'b0;
            exe_rst     = 1'b1;
            pc_src_ctrl = PC_NEXT;
            w_stall     = 1'b1;
        end else if (w_redirect) begin
            if (!DELAY_SLOT) begin
                id_rst  = 1'b1;
                w_flush = 1'b1;
            end
        end else if (!inst_ack) begin
            if_en   = 1'b0;
            id_rst  = 1'b1;
            w_stall = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_mem_stall) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ack)     w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            mem_timeout <= 1'b0;
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            cyc_cnt <= cyc_cnt + 1'b1;
            if (w_stall) stall_cnt <= stall_cnt + 1'b1;
            if (w_flush) flush_cnt <= flush_cnt + 1'b1;
            if (r_state == ST_MEM_WAIT && !mem_ack) begin
                if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=2, CNT_W=16, DELAY_SLOT=0).
module tb_pipeline_ctrl;

    localparam logic [2:0] PC_NEXT   = 3'd0;
    localparam logic [2:0] PC_JUMP   = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem;
    logic        rs_used, rt_used, is_store_id, is_beq, is_bne, a_b_equal;
    logic [2:0]  pc_src_dec;
    logic        wb_wen_exe, wb_wen_mem, is_load_exe, mem_ren_mem, mem_wen_mem;
    logic        inst_ack, mem_ack;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0]  fwd_a_ctrl, fwd_b_ctrl;
    logic        fwd_m, mem_timeout;
    logic [2:0]  pc_src_ctrl;
    logic [15:0] cyc_cnt, stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int e_cyc   = 0;

    pipeline_ctrl #(.TIMEOUT(2), .CNT_W(16), .DELAY_SLOT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .is_store_id(is_store_id),
        .is_beq(is_beq), .is_bne(is_bne), .pc_src_dec(pc_src_dec), .a_b_equal(a_b_equal),
        .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem),
        .is_load_exe(is_load_exe), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .inst_ack(inst_ack), .mem_ack(mem_ack),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .fwd_a_ctrl(fwd_a_ctrl), .fwd_b_ctrl(fwd_b_ctrl), .fwd_m(fwd_m),
        .pc_src_ctrl(pc_src_ctrl), .mem_timeout(mem_timeout),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        addr_rs_id = 5'd0; addr_rt_id = 5'd0; regw_addr_exe = 5'd0; regw_addr_mem = 5'd0;
        rs_used = 1'b0; rt_used = 1'b0; is_store_id = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        a_b_equal = 1'b0; pc_src_dec = PC_NEXT; wb_wen_exe = 1'b0; wb_wen_mem = 1'b0;
        is_load_exe = 1'b0; mem_ren_mem = 1'b0; mem_wen_mem = 1'b0;
        inst_ack = 1'b1; mem_ack = 1'b0;
    endtask

    // Advance one clock; sample registered outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) e_cyc = 0; else e_cyc++;
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int stl, input int fl);
        chk({tag, "_cyc"}, {16'd0, cyc_cnt}, e_cyc);
        chk({tag, "_stall"}, {16'd0, stall_cnt}, stl);
        chk({tag, "_flush"}, {16'd0, flush_cnt}, fl);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // hazard present during reset must not leak to outputs
        addr_rs_id = 5'd1; rs_used = 1'b1; regw_addr_exe = 5'd1; wb_wen_exe = 1'b1;
        #1;
        chk("rst_rsts", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b11111);
        chk("rst_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        chk("rst_fwd_a", fwd_a_ctrl, 2'b00);
        chk("rst_pc", pc_src_ctrl, PC_NEXT);
        tick(); tick();
        chk_cnt("rst", 0, 0);
        chk("rst_timeout", mem_timeout, 1'b0);
        rst = 1'b0;

        idle(); #1;
        chk("run_rsts", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b00000);
        chk("run_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        tick();

        // add $1; add $2,$1,$3
        idle(); addr_rs_id = 5'd1; addr_rt_id = 5'd3; rs_used = 1'b1; rt_used = 1'b1;
        regw_addr_exe = 5'd1; wb_wen_exe = 1'b1; #1;
        chk("fwd_exe_a", fwd_a_ctrl, 2'b01);
        chk("fwd_exe_b", fwd_b_ctrl, 2'b00);
        chk("fwd_exe_ifen", if_en, 1'b1);
        tick();
        // one instruction later: $1 now in MEM
        idle(); addr_rs_id = 5'd1; rs_used = 1'b1; regw_addr_exe = 5'd2; wb_wen_exe = 1'b1;
        regw_addr_mem = 5'd1; wb_wen_mem = 1'b1; #1;
        chk("fwd_mem_a", fwd_a_ctrl, 2'b10);
        tick();
        // EXE beats MEM when both match; $0 never forwards
        idle(); addr_rs_id = 5'd1; addr_rt_id = 5'd0; rs_used = 1'b1; rt_used = 1'b1;
        regw_addr_exe = 5'd1; wb_wen_exe = 1'b1; regw_addr_mem = 5'd1; wb_wen_mem = 1'b1; #1;
        chk("fwd_prio_a", fwd_a_ctrl, 2'b01);
        regw_addr_exe = 5'd0; regw_addr_mem = 5'd0; addr_rs_id = 5'd0; #1;
        chk("fwd_r0_a", fwd_a_ctrl, 2'b00);
        chk("fwd_r0_b", fwd_b_ctrl, 2'b00);
        tick();
        chk_cnt("fwd", 0, 0);

        // lw $4; add $5,$4,$4
        idle(); addr_rs_id = 5'd4; addr_rt_id = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
        is_load_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = 5'd4; #1;
        chk("lu_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00111);
        chk("lu_rsts", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b00100);
        tick();
        chk_cnt("lu", 1, 0);
        idle(); addr_rs_id = 5'd4; addr_rt_id = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
        regw_addr_mem = 5'd4; wb_wen_mem = 1'b1; mem_ren_mem = 1'b1; mem_ack = 1'b1; #1;
        chk("lu_fwd_a", fwd_a_ctrl, 2'b11);
        chk("lu_fwd_b", fwd_b_ctrl, 2'b11);
        chk("lu_after_ifen", if_en, 1'b1);
        tick();

        // lw $4; sw $4,0($6)
        idle(); addr_rs_id = 5'd6; addr_rt_id = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
        is_store_id = 1'b1; is_load_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = 5'd4; #1;
        chk("st_fwd_m", fwd_m, 1'b1);
        chk("st_ens", {if_en, id_en, exe_en}, 3'b111);
        tick();
        chk_cnt("st", 1, 0);

        // beq taken, with inst_ack low (ignored on redirect)
        idle(); is_beq = 1'b1; a_b_equal = 1'b1; inst_ack = 1'b0; #1;
        chk("beq_t_pc", pc_src_ctrl, PC_BRANCH);
        chk("beq_t_idrst", id_rst, 1'b1);
        chk("beq_t_ifen", if_en, 1'b1);
        tick();
        chk_cnt("beq_t", 1, 1);
        idle(); is_beq = 1'b1; a_b_equal = 1'b0; #1;
        chk("beq_nt_pc", pc_src_ctrl, PC_NEXT);
        chk("beq_nt_idrst", id_rst, 1'b0);
        tick();
        idle(); is_bne = 1'b1; a_b_equal = 1'b0; #1;
        chk("bne_t_pc", pc_src_ctrl, PC_BRANCH);
        tick();
        idle(); pc_src_dec = PC_JUMP; #1;
        chk("j_pc", pc_src_ctrl, PC_JUMP);
        chk("j_idrst", id_rst, 1'b1);
        tick();
        chk_cnt("br", 1, 3);

        // fetch not acknowledged
        idle(); inst_ack = 1'b0; #1;
        chk("ia_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b01111);
        chk("ia_rsts", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b01000);
        tick();
        chk_cnt("ia", 2, 3);

        // load in MEM, mem_ack low for 3 cycles; TIMEOUT=2
        idle(); mem_ren_mem = 1'b1; wb_wen_mem = 1'b1; regw_addr_mem = 5'd7; #1;
        chk("ms1_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        chk("ms1_rsts", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b00000);
        tick();
        chk("ms2_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        tick();
        chk("ms_to_early", mem_timeout, 1'b0);
        chk("ms3_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        tick();
        chk("ms_to_set", mem_timeout, 1'b1);
        chk_cnt("ms", 5, 3);
        mem_ack = 1'b1; #1;
        chk("ms_ack_ens", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        tick();
        idle(); tick();
        chk("ms_to_sticky", mem_timeout, 1'b1);
        chk_cnt("ms_done", 5, 3);

        // load-use coincident with taken beq: stall wins
        idle(); is_beq = 1'b1; a_b_equal = 1'b1; addr_rs_id = 5'd4; addr_rt_id = 5'd5;
        rs_used = 1'b1; rt_used = 1'b1; is_load_exe = 1'b1; wb_wen_exe = 1'b1;
        regw_addr_exe = 5'd4; #1;
        chk("lub_ens", {if_en, id_en}, 2'b00);
        chk("lub_rsts", {id_rst, exe_rst}, 2'b01);
        tick();
        chk_cnt("lub", 6, 3);
        idle(); is_beq = 1'b1; a_b_equal = 1'b1; addr_rs_id = 5'd4; addr_rt_id = 5'd5;
        rs_used = 1'b1; rt_used = 1'b1; regw_addr_mem = 5'd4; wb_wen_mem = 1'b1;
        mem_ren_mem = 1'b1; mem_ack = 1'b1; #1;
        chk("lub2_fwd_a", fwd_a_ctrl, 2'b11);
        chk("lub2_pc", pc_src_ctrl, PC_BRANCH);
        chk("lub2_idrst", id_rst, 1'b1);
        tick();
        chk_cnt("lub2", 6, 4);

        // reset in the middle of a memory wait
        idle(); mem_ren_mem = 1'b1; tick(); tick();
        rst = 1'b1; tick();
        chk_cnt("mrst", 0, 0);
        chk("mrst_timeout", mem_timeout, 1'b0);
        rst = 1'b0; idle(); tick();
        chk_cnt("mrst_run", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
